// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared state encoding, memory size default and big-endian lane constants
package mem_access_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RD, RDW, WR} state_t;
  localparam int MEM_BYTES_DEFAULT = 64;
  localparam int LANE_BITS = 8;
  localparam logic [1:0] LANE_HI = 2'd0;
  localparam logic [1:0] LANE_LO = 2'd3;
  function automatic logic [4:0] lane_shift(input logic [1:0] offset);
    return {LANE_LO - offset, 3'b000};
  endfunction
endpackage

// File: rtl/mem_lane_mux.sv
// mem_lane_mux: big-endian byte lane extract/extend for loads and lane merge for byte stores
module mem_lane_mux
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic        is_byte,
  input  logic        is_signed,
  input  logic [7:0]  wbyte,
  output logic [31:0] load,
  output logic [31:0] merged
);
  logic [4:0] sh;
  logic [LANE_BITS-1:0] lane;
  assign sh = lane_shift(offset);
  assign lane = LANE_BITS'(data >> sh);
  assign load = !is_byte ? data : is_signed ? {{24{lane[7]}}, lane} : {24'b0, lane};
  assign merged = (data & ~(32'h0000_00ff << sh)) | (32'(wbyte) << sh);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: word/byte load-store controller over a word-wide memory with read-modify-write byte stores
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic        memoryWrite,
  output logic        memoryRead,
  input  logic [31:0] readData
);
  state_t state;
  logic wr, byt, sgn, bad;
  logic [31:0] addr, wdata, load, merged;
  assign req_ready = state == IDLE;
  assign memoryRead = state == RD;
  assign memoryWrite = state == WR;
  assign address = (memoryRead || memoryWrite) ? {addr[31:2], 2'b00} : '0;
  assign writeData = memoryWrite ? wdata : '0;
  assign bad = (req_addr >= 32'(MEM_BYTES)) || (!req_byte && req_addr[1:0] != 2'b00);
  mem_lane_mux u_lane (
    .data(readData),
    .offset(addr[1:0]),
    .is_byte(byt),
    .is_signed(sgn),
    .wbyte(wdata[7:0]),
    .load(load),
    .merged(merged)
  );
  // Byte stores reuse the load path, then overwrite wdata with the merged word before WR
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
      wr <= 1'b0;
      byt <= 1'b0;
      sgn <= 1'b0;
      addr <= '0;
      wdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          wr <= req_write;
          byt <= req_byte;
          sgn <= req_signed;
          addr <= req_addr;
          wdata <= req_wdata;
          if (bad) begin
            resp_valid <= 1'b1;
            resp_err <= 1'b1;
            resp_rdata <= '0;
          end else begin
            state <= (req_write && !req_byte) ? WR : RD;
          end
        end
        RD: state <= RDW;
        RDW: if (wr) begin
          wdata <= merged;
          state <= WR;
        end else begin
          resp_valid <= 1'b1;
          resp_err <= 1'b0;
          resp_rdata <= load;
          state <= IDLE;
        end
        WR: begin
          resp_valid <= 1'b1;
          resp_err <= 1'b0;
          resp_rdata <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
